fpin_event_gen: RTL and testbench

//  Front-panel input side of the EVR: mirror of the front-panel output mapping. Synchronises FrontIn pins,

---
 rtl/fpin_event_gen.sv | 147 ++++++++++++++
 tb/tb_fpin_event_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpin_event_gen.sv
// fpin_event_gen: detects per-input edges on front-panel pins and queues their event codes in a FWFT FIFO.
// Latency: pin change sampled at edge k gives ev_valid after edge k+SYNC_STAGES+2, +FILT_LEN with FPIN_FILTER_EN.
// Backpressure: a full FIFO holds codes in per-input pending flags; a repeat edge on a pending input sets overflow.
module fpin_event_gen #(
    parameter int N_IN        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_IN-1:0]               FrontIn,
    input  logic [N_IN-1:0]               FPIn_en,
    input  logic [N_IN-1:0]               FPIn_edge,
    input  logic [8*N_IN-1:0]             FPIn_code,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    input  logic                          ev_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FPIN_FILTER_EN
    // The filter adds a stage between sync and prev, so the settling window is one cycle longer.
    localparam int ARM_N = SYNC_STAGES + 2;
`else
    localparam int ARM_N = SYNC_STAGES + 1;
`endif
    localparam int ARMW = $clog2(ARM_N + 1);

    logic [N_IN-1:0] sync_q [SYNC_STAGES];
    logic [N_IN-1:0] lvl;
    logic [N_IN-1:0] prev_q;
    logic [N_IN-1:0] edge_q;
    logic [N_IN-1:0] edge_d;
    logic [N_IN-1:0] code_nz;
    logic [N_IN-1:0] pend_q;
    logic [N_IN-1:0] pend_d;
    logic [N_IN-1:0] gnt;
    logic [N_IN-1:0] clr;
    logic [ARMW-1:0] arm_q;
    logic            armed;
    logic            ovf_q;
    logic            ovf_set;
    logic            found;
    logic            push;
    logic            pop;
    logic            full;
    logic [7:0]      wr_code;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_q;
    logic [AW:0]     rd_q;

    assign armed = (arm_q == ARMW'(ARM_N));

`ifdef FPIN_FILTER_EN
    localparam int CW = $clog2(FILT_LEN) + 1;
    logic [N_IN-1:0] filt_q;
    logic [CW-1:0]   cnt_q [N_IN];

    // While disarmed the filter follows the synced level so a pin held at reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (!armed || sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
                    filt_q[i] <= sync_q[SYNC_STAGES-1][i];
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync_q[SYNC_STAGES-1][i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i]  <= cnt_q[i] + CW'(1);
                end
            end
        end
    end
    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        for (int i = 0; i < N_IN; i++) code_nz[i] = |FPIn_code[8*i +: 8];
    end

    assign edge_d = armed ? (((FPIn_edge & lvl & ~prev_q) | (~FPIn_edge & ~lvl & prev_q)) & FPIn_en & code_nz)
                          : '0;

    assign fifo_level = wr_q - rd_q;
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign ev_valid   = (fifo_level != '0);
    assign ev_code    = ev_valid ? mem[rd_q[AW-1:0]] : 8'h00;
    assign pop        = ev_valid & ev_ready;
    assign overflow   = ovf_q;

    // Fixed-priority scan: lowest pending index wins the single write slot.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        wr_code = 8'h00;
        for (int i = 0; i < N_IN; i++) begin
            if (pend_q[i] && !found) begin
                gnt[i]  = 1'b1;
                found   = 1'b1;
                wr_code = FPIn_code[8*i +: 8];
            end
        end
    end

    assign push    = found & (~full | pop);
    assign clr     = push ? gnt : '0;
    assign pend_d  = (edge_q | (pend_q & ~clr)) & FPIn_en;
    assign ovf_set = |(edge_q & pend_q & ~clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
            prev_q <= '0;
            edge_q <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            arm_q  <= '0;
        end else begin
            sync_q[0] <= FrontIn;
            for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
            prev_q <= lvl;
            edge_q <= edge_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_set | (ovf_q & ~ovf_clr);
            if (push)   wr_q  <= wr_q + (AW+1)'(1);
            if (pop)    rd_q  <= rd_q + (AW+1)'(1);
            if (!armed) arm_q <= arm_q + ARMW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= wr_code;
    end

endmodule

// File: tb/tb_fpin_event_gen.sv
// Directed bench for fpin_event_gen: reset, latency, scan order, saturation, overflow, mid-run reset.
module tb_fpin_event_gen;

`ifdef FPIN_FILTER_EN
    localparam int XL = 16;
`else
    localparam int XL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  FrontIn;
    logic [3:0]  FPIn_en;
    logic [3:0]  FPIn_edge;
    logic [31:0] FPIn_code;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_ready;
    logic        overflow;
    logic        ovf_clr;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpin_event_gen dut (
        .clk(clk), .rst_n(rst_n), .FrontIn(FrontIn), .FPIn_en(FPIn_en), .FPIn_edge(FPIn_edge),
        .FPIn_code(FPIn_code), .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
        .overflow(overflow), .ovf_clr(ovf_clr), .fifo_level(fifo_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; FrontIn = 4'b0001; FPIn_en = 4'hF; FPIn_edge = 4'hF;
        FPIn_code = {8'h13, 8'h12, 8'h11, 8'h7A}; ev_ready = 1'b1; ovf_clr = 1'b0;
        wait_n(3);
        checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", ev_valid); end
        checks++; if (ev_code !== 8'h00) begin failures++; $display("FAIL rst_code got %h want 00", ev_code); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got %b want 0", overflow); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        rst_n = 1'b1;
        seen = 0;
        repeat (20 + XL) begin tick(); if (ev_valid) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL held_high_event got %0d valid cycles want 0", seen); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL held_high_ovf got %b want 0", overflow); end
    endtask

    task automatic test_latency();
        int first, nvalid;
        logic [7:0] code;
        FrontIn = 4'b0000;
        wait_n(6 + XL);
        FrontIn = 4'b0001;
        first = -1; nvalid = 0; code = 8'h00;
        for (int c = 1; c <= 12 + XL; c++) begin
            tick();
            if (ev_valid) begin
                if (first < 0) begin first = c; code = ev_code; end
                nvalid++;
            end
        end
        checks++; if (first != 5 + XL) begin failures++; $display("FAIL lat_cycle got %0d want %0d", first, 5 + XL); end
        checks++; if (nvalid != 1) begin failures++; $display("FAIL lat_width got %0d want 1", nvalid); end
        checks++; if (code !== 8'h7A) begin failures++; $display("FAIL lat_code got %h want 7a", code); end
    endtask

    task automatic test_multi();
        int first;
        bit gap;
        logic [7:0] got[$];
        logic [7:0] exp_c [4];
        exp_c = '{8'h10, 8'h11, 8'h12, 8'h13};
        FPIn_code = {8'h13, 8'h12, 8'h11, 8'h10};
        FrontIn = 4'b0000;
        wait_n(6 + XL);
        FrontIn = 4'b1111;
        first = -1; gap = 1'b0;
        for (int c = 1; c <= 12 + XL; c++) begin
            tick();
            if (ev_valid) begin
                if (first < 0) first = c;
                if (c != first + got.size()) gap = 1'b1;
                got.push_back(ev_code);
            end
        end
        checks++; if (first != 5 + XL) begin failures++; $display("FAIL multi_first got %0d want %0d", first, 5 + XL); end
        checks++; if (gap) begin failures++; $display("FAIL multi_consecutive got gap want none"); end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL multi_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_c[i]) begin failures++; $display("FAIL multi_code[%0d] got %h want %h", i, got[i], exp_c[i]); end
        end
    endtask

    task automatic test_qualify();
        logic [7:0] got[$];
        FrontIn = 4'b0000;
        wait_n(6 + XL);
        FPIn_en = 4'b1011;
        FPIn_code = {8'h00, 8'h12, 8'h11, 8'h10};
        FrontIn = 4'b1111;
        repeat (14 + XL) begin tick(); if (ev_valid) got.push_back(ev_code); end
        checks++; if (got.size() != 2) begin failures++; $display("FAIL qual_count got %0d want 2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 8'h10 || got[1] !== 8'h11) begin
                failures++; $display("FAIL qual_codes got %h,%h want 10,11", got[0], got[1]); end
        end
        FPIn_en = 4'hF;
        FPIn_code = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    task automatic round(input logic [3:0] mask);
        FrontIn = 4'b0000;
        wait_n(8 + XL);
        FrontIn = mask;
        wait_n(10 + XL);
    endtask

    task automatic test_full();
        logic [7:0] got[$];
        logic [7:0] exp_c [10];
        exp_c = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        ev_ready = 1'b0;
        round(4'b1111);
        checks++; if (fifo_level !== 4'd4) begin failures++; $display("FAIL full_round1 got %0d want 4", fifo_level); end
        round(4'b1111);
        round(4'b0011);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level got %0d want 8", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got %b want 0", overflow); end
        ev_ready = 1'b1;
        repeat (30) begin if (ev_valid) got.push_back(ev_code); tick(); end
        checks++; if (got.size() != 10) begin failures++; $display("FAIL drain_count got %0d want 10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_c[i]) begin failures++; $display("FAIL drain_code[%0d] got %h want %h", i, got[i], exp_c[i]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL drain_ovf got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        ev_ready = 1'b0;
        round(4'b1111);
        round(4'b1111);
        FrontIn[1] = 1'b0; wait_n(4 + XL);
        FrontIn[1] = 1'b1; wait_n(6 + XL);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_first_pulse got %b want 0", overflow); end
        FrontIn[1] = 1'b0; wait_n(4 + XL);
        FrontIn[1] = 1'b1; wait_n(6 + XL);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b want 1", overflow); end
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got %b want 0", overflow); end
        ev_ready = 1'b1;
        wait_n(20);
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL ovf_drain got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        int seen;
        ev_ready = 1'b0;
        round(4'b1111);
        checks++; if (fifo_level !== 4'd4) begin failures++; $display("FAIL mid_pre got %0d want 4", fifo_level); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (ev_valid !== 1'b0 || fifo_level !== 4'd0) begin
            failures++; $display("FAIL mid_reset got valid=%b level=%0d want 0/0", ev_valid, fifo_level); end
        ev_ready = 1'b1;
        seen = 0;
        repeat (20 + XL) begin tick(); if (ev_valid) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_after got %0d valid cycles want 0", seen); end
    endtask

`ifdef FPIN_FILTER_EN
    task automatic test_filter();
        int seen;
        logic [7:0] code;
        ev_ready = 1'b1;
        FrontIn = 4'b0000;
        wait_n(40);
        FrontIn[2] = 1'b1; wait_n(5); FrontIn[2] = 1'b0;
        seen = 0;
        repeat (40) begin tick(); if (ev_valid) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL filt_glitch got %0d events want 0", seen); end
        FrontIn[2] = 1'b1;
        seen = 0; code = 8'h00;
        for (int c = 0; c < 60; c++) begin
            if (c == 20) FrontIn[2] = 1'b0;
            tick();
            if (ev_valid) begin seen++; code = ev_code; end
        end
        checks++; if (seen != 1 || code !== 8'h12) begin
            failures++; $display("FAIL filt_pulse got %0d events code %h want 1 code 12", seen, code); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_multi();
        test_qualify();
        test_full();
        test_overflow();
        test_reset_mid();
`ifdef FPIN_FILTER_EN
        test_filter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
